// File: rtl/rotary_multi_hex.sv
// Multi-channel rotary dial front end: synchronise, debounce, decode detents,
// count per channel and render every count nibble as an active-low 7-seg digit.
module rotary_multi_hex #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned DEBOUNCE = 500,
  parameter int unsigned SATURATE = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [2*CHANNELS-1:0]           rotary_in,
  input  logic [CHANNELS-1:0]             clear,
  output logic [CHANNELS-1:0]             rotary_cw,
  output logic [CHANNELS-1:0]             rotary_ccw,
  output logic [CHANNELS*COUNT_W-1:0]     count,
  output logic [7*CHANNELS*COUNT_W/4-1:0] hex
);

  localparam int unsigned BITS   = 2 * CHANNELS;
  localparam int unsigned DIGITS = CHANNELS * COUNT_W / 4;
  localparam int unsigned DB_W   = (DEBOUNCE == 0) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  logic [BITS-1:0] sync1;
  logic [BITS-1:0] sync2;
  logic [BITS-1:0] filt;

  // Two-flop synchroniser for the asynchronous dial pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= rotary_in;
      sync2 <= sync1;
    end
  end

  for (genvar b = 0; b < BITS; b++) begin : g_bit
    logic f;
    assign filt[b] = f;

    if (DEBOUNCE == 0) begin : g_bypass
      // Filter bypassed: follow the synchronised pin directly.
      always_ff @(posedge clk) begin
        if (!reset_n) f <= 1'b0;
        else          f <= sync2[b];
      end
    end else begin : g_filter
      logic [DB_W-1:0] stable;

      // Accept a new level only after it has differed from filt long enough.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          f      <= 1'b0;
          stable <= '0;
        end else if (sync2[b] == f) begin
          stable <= '0;
        end else if (stable == DB_W'(DEBOUNCE - 1)) begin
          f      <= sync2[b];
          stable <= '0;
        end else begin
          stable <= stable + DB_W'(1);
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0]         prev;
    logic [1:0]         cur;
    logic               cw_evt;
    logic               ccw_evt;
    logic               cw_q;
    logic               ccw_q;
    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] cnt_next;

    // A detent is entering 00 from a single-bit neighbour; the neighbour sets direction.
    assign cur     = filt[2*c +: 2];
    assign cw_evt  = (prev == 2'b01) && (cur == 2'b00);
    assign ccw_evt = (prev == 2'b10) && (cur == 2'b00);

    assign rotary_cw[c]                 = cw_q;
    assign rotary_ccw[c]                = ccw_q;
    assign count[c*COUNT_W +: COUNT_W]  = cnt;

    // Next count: clear wins, then step with optional clamping at the limits.
    always_comb begin
      cnt_next = cnt;
      if (clear[c]) begin
        cnt_next = '0;
      end else if (cw_evt) begin
        if (SATURATE == 0 || cnt != CNT_MAX) cnt_next = cnt + COUNT_W'(1);
      end else if (ccw_evt) begin
        if (SATURATE == 0 || cnt != '0) cnt_next = cnt - COUNT_W'(1);
      end
    end

    // Registered event pulses, previous filtered state and counter.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        prev  <= 2'b00;
        cw_q  <= 1'b0;
        ccw_q <= 1'b0;
        cnt   <= '0;
      end else begin
        prev  <= cur;
        cw_q  <= cw_evt;
        ccw_q <= ccw_evt;
        cnt   <= cnt_next;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Registered segment decode of every nibble of the concatenated counts.
  always_ff @(posedge clk) begin
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (!reset_n) hex[7*d +: 7] <= SEG_ZERO;
      else          hex[7*d +: 7] <= seg7(count[4*d +: 4]);
    end
  end

endmodule

// File: tb/tb_rotary_multi_hex.sv
// Directed bench: three instances (fast debounce/wrap, bypass/saturate, long debounce).
module tb_rotary_multi_hex;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] SF = 7'b0001110;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  rin_a, rin_s, rin_g;
  logic [1:0]  clr_a, clr_s, clr_g;
  logic [1:0]  cw_a, ccw_a, cw_s, ccw_s, cw_g, ccw_g;
  logic [15:0] cnt_a, cnt_s, cnt_g;
  logic [27:0] hex_a, hex_s, hex_g;

  int checks = 0;
  int errors = 0;
  int cw_seen[3][2];
  int ccw_seen[3][2];
  int both_seen = 0;

  always #10 clk = ~clk;

  rotary_multi_hex #(.CHANNELS(2), .COUNT_W(8), .DEBOUNCE(4), .SATURATE(0)) u_a (
    .clk(clk), .reset_n(reset_n), .rotary_in(rin_a), .clear(clr_a),
    .rotary_cw(cw_a), .rotary_ccw(ccw_a), .count(cnt_a), .hex(hex_a));

  rotary_multi_hex #(.CHANNELS(2), .COUNT_W(8), .DEBOUNCE(0), .SATURATE(1)) u_s (
    .clk(clk), .reset_n(reset_n), .rotary_in(rin_s), .clear(clr_s),
    .rotary_cw(cw_s), .rotary_ccw(ccw_s), .count(cnt_s), .hex(hex_s));

  rotary_multi_hex #(.CHANNELS(2), .COUNT_W(8), .DEBOUNCE(500), .SATURATE(0)) u_g (
    .clk(clk), .reset_n(reset_n), .rotary_in(rin_g), .clear(clr_g),
    .rotary_cw(cw_g), .rotary_ccw(ccw_g), .count(cnt_g), .hex(hex_g));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Count pulses away from the clock edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      for (int c = 0; c < 2; c++) begin
        cw_seen[0][c]  += int'(cw_a[c]);
        ccw_seen[0][c] += int'(ccw_a[c]);
        cw_seen[1][c]  += int'(cw_s[c]);
        ccw_seen[1][c] += int'(ccw_s[c]);
        cw_seen[2][c]  += int'(cw_g[c]);
        ccw_seen[2][c] += int'(ccw_g[c]);
      end
      if (((cw_a & ccw_a) | (cw_s & ccw_s) | (cw_g & ccw_g)) != 2'b00) both_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input int inst, input int ch, input logic [1:0] v);
    case (inst)
      0:       rin_a[2*ch +: 2] = v;
      1:       rin_s[2*ch +: 2] = v;
      default: rin_g[2*ch +: 2] = v;
    endcase
  endtask

  function automatic logic get_pulse(input int inst, input int ch, input bit is_cw);
    case (inst)
      0:       return is_cw ? cw_a[ch] : ccw_a[ch];
      1:       return is_cw ? cw_s[ch] : ccw_s[ch];
      default: return is_cw ? cw_g[ch] : ccw_g[ch];
    endcase
  endfunction

  function automatic int total_pulses();
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 2; c++) s += cw_seen[i][c] + ccw_seen[i][c];
    return s;
  endfunction

  // One detent from rest (11). When timed, checks the pulse lands exactly on the
  // 7th edge after 00 is applied; clr raises clear on that same edge (instance a).
  task automatic detent(input int inst, input int ch, input bit is_cw, input int settle,
                        input bit timed, input bit clr);
    logic [1:0] first, last;
    first = is_cw ? 2'b01 : 2'b10;
    last  = is_cw ? 2'b10 : 2'b01;
    set_pins(inst, ch, first);
    tick(settle);
    set_pins(inst, ch, 2'b00);
    if (timed) begin
      tick(6);
      check("pulse_early", 32'(get_pulse(inst, ch, is_cw)), 0);
      if (clr) clr_a[ch] = 1'b1;
      tick(1);
      check("pulse_on_time", 32'(get_pulse(inst, ch, is_cw)), 1);
      check("pulse_opposite", 32'(get_pulse(inst, ch, !is_cw)), 0);
      clr_a = 2'b00;
    end
    tick(settle);
    set_pins(inst, ch, last);
    tick(settle);
    set_pins(inst, ch, 2'b11);
    tick(settle);
  endtask

  initial begin
    reset_n = 1'b0;
    rin_a = 4'hF; rin_s = 4'hF; rin_g = 4'hF;
    clr_a = 2'b00; clr_s = 2'b00; clr_g = 2'b00;
    tick(3);
    check("rst_count_a", cnt_a, 16'h0000);
    check("rst_count_s", cnt_s, 16'h0000);
    check("rst_hex_a", hex_a, {S0, S0, S0, S0});
    check("rst_pulses_a", {cw_a, ccw_a}, 4'b0000);

    reset_n = 1'b1;
    tick(600);
    check("idle_count_a", cnt_a, 16'h0000);
    check("idle_count_g", cnt_g, 16'h0000);
    check("idle_pulses", total_pulses(), 0);

    // Three clockwise detents on instance a channel 0.
    for (int i = 0; i < 3; i++) detent(0, 0, 1'b1, 10, 1'b1, 1'b0);
    check("cw_pulse_count", cw_seen[0][0], 3);
    check("cw_count", cnt_a[7:0], 8'h03);
    check("cw_hex0", hex_a[6:0], S3);
    check("cw_hex1", hex_a[13:7], S0);

    // Four ccw detents: 3 -> 0 -> 0xFF (wrap down), then cw wraps back to 0.
    for (int i = 0; i < 4; i++) detent(0, 0, 1'b0, 10, 1'b1, 1'b0);
    check("wrap_down", cnt_a[7:0], 8'hFF);
    check("wrap_down_hex", hex_a[13:0], {SF, SF});
    detent(0, 0, 1'b1, 10, 1'b1, 1'b0);
    check("wrap_up", cnt_a[7:0], 8'h00);

    // Clear on channel 1 coinciding with a ccw event at count 5.
    detent(0, 0, 1'b1, 10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) detent(0, 1, 1'b1, 10, 1'b0, 1'b0);
    check("ch1_before_clear", cnt_a[15:8], 8'h05);
    detent(0, 1, 1'b0, 10, 1'b1, 1'b1);
    check("clear_count_ch1", cnt_a[15:8], 8'h00);
    check("clear_ch0_kept", cnt_a[7:0], 8'h01);
    check("clear_ccw_seen", ccw_seen[0][1], 1);
    check("clear_hex", hex_a, {S0, S0, S0, 7'b1111001});

    // Simultaneous cw on ch0 and ccw on ch1.
    rin_a = 4'b1001;
    tick(10);
    rin_a = 4'b0000;
    tick(7);
    check("multi_cw0", 32'(cw_a[0]), 1);
    check("multi_ccw1", 32'(ccw_a[1]), 1);
    tick(10);
    rin_a = 4'b0110;
    tick(10);
    rin_a = 4'b1111;
    tick(10);
    check("multi_count", cnt_a, 16'hFF02);
    check("multi_hex", hex_a, {SF, SF, S0, S2});

    // Saturating instance: clamp at 0 and at 0xFF, pulses still emitted.
    detent(1, 0, 1'b0, 5, 1'b0, 1'b0);
    check("sat_low", cnt_s[7:0], 8'h00);
    check("sat_low_pulse", ccw_seen[1][0], 1);
    for (int i = 0; i < 255; i++) detent(1, 0, 1'b1, 5, 1'b0, 1'b0);
    check("sat_reach_max", cnt_s[7:0], 8'hFF);
    detent(1, 0, 1'b1, 5, 1'b0, 1'b0);
    check("sat_high", cnt_s[7:0], 8'hFF);
    check("sat_high_pulse", cw_seen[1][0], 256);

    // Illegal double change 11 -> 00 with the filter bypassed.
    rin_s[1:0] = 2'b00;
    tick(6);
    rin_s[1:0] = 2'b11;
    tick(6);
    check("illegal_count", cnt_s[7:0], 8'hFF);
    check("illegal_cw", cw_seen[1][0], 256);
    check("illegal_ccw", ccw_seen[1][0], 1);
    check("sat_ch1_idle", cnt_s[15:8], 8'h00);

    // 499-cycle glitch into 00 from 01 must not pass the 500-cycle filter.
    rin_g[1:0] = 2'b01;
    tick(510);
    rin_g[1:0] = 2'b00;
    tick(499);
    rin_g[1:0] = 2'b01;
    tick(520);
    check("glitch_count", cnt_g, 16'h0000);
    check("glitch_pulses", cw_seen[2][0] + ccw_seen[2][0], 0);
    rin_g[1:0] = 2'b00;
    tick(510);
    check("slow_cw_count", cnt_g[7:0], 8'h01);
    check("slow_cw_pulse", cw_seen[2][0], 1);
    rin_g[1:0] = 2'b10;
    tick(510);
    rin_g[1:0] = 2'b11;
    tick(510);
    check("slow_final", cnt_g, 16'h0001);

    check("never_both", both_seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotary_multi_hex.md
# rotary_multi_hex

Parametrised multi-channel rotary-dial front end for the display board. It synchronises and debounces each dial's quadrature pair, then decodes detent steps into clockwise and counter-clockwise event pulses. Each channel keeps a wrapping or saturating position counter, and all counters are rendered as active-low seven-segment digits. It replaces the fixed single-dial, two-digit rotary-to-hex path and drives HEX0..HEX5 directly from the dial inputs.

## Interface
- CHANNELS, 2: number of dials, legal range 1..3.
- COUNT_W, 8: counter width per channel, a multiple of 4 in the range 4..12. CHANNELS*COUNT_W/4 must be ≤ 6.
- DEBOUNCE, 500: number of consecutive stable cycles required before a filtered bit changes. 0 bypasses the filter.
- SATURATE, 0: selects the counter mode. 0 = wrap modulo 2^COUNT_W; 1 = clamp at 0 and 2^COUNT_W-1.

- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  reset; synchronous, active-low.
- rotary_in  in  2*CHANNELS  asynchronous dial pins. Bits [2c+1:2c] = {B,A} of channel c.
- clear  in  CHANNELS  synchronous per-channel counter clear, active-high.
- rotary_cw  out  CHANNELS  one-cycle pulse per clockwise detent.
- rotary_ccw  out  CHANNELS  one-cycle pulse per counter-clockwise detent.
- count  out  CHANNELS*COUNT_W  channel c occupies bits [c*COUNT_W +: COUNT_W].
- hex  out  7*CHANNELS*COUNT_W/4  active-low segments {g,f,e,d,c,b,a} per digit. Digit d = nibble d of the concatenated count vector, with digit 0 = channel 0's low nibble.

## Operation
- **Synchroniser.** Each rotary_in bit passes through two flops, sync1 then sync2.
- **Debounce (per bit).**
  - Each bit has a filtered register `filt` and a stability counter of width $clog2(DEBOUNCE+1).
  - When sync2 == filt, the counter clears.
  - When sync2 != filt, the counter increments. When it reaches DEBOUNCE-1, `filt` takes sync2 on that edge and the counter clears.
  - Any return to sync2 == filt before that point clears the counter, so a glitch shorter than DEBOUNCE cycles never reaches `filt`.
  - DEBOUNCE=0: `filt` <= sync2 every cycle.
- **Decode (per channel).** The block compares previous {B,A} `filt` with the current one.
  - 01 → 00 asserts rotary_cw for 1 cycle.
  - 10 → 00 asserts rotary_ccw for 1 cycle.
  - All other transitions produce no event. This includes 11 → 00 (illegal double change), 00 → xx, and no change.
  - rotary_cw and rotary_ccw are never high together on one channel.
- **Counter (per channel).**
  - A cw event adds 1 and a ccw event subtracts 1, both at COUNT_W bits.
  - SATURATE=0: the counter wraps, so 2^COUNT_W-1 + 1 = 0 and 0 - 1 = 2^COUNT_W-1.
  - SATURATE=1: the counter holds at the limit instead of wrapping. The event pulse is still emitted.
  - clear has priority over any event in the same cycle: the count becomes 0, and the pulse is still emitted.
- **Hex.**
  - Registered 4-bit to 7-segment decode for 0..F. The codes are:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
  - Channels are independent; events on different channels in the same cycle are all processed.

## Timing
- **Reset (reset_n low at an edge).** Reset takes effect on that clock edge:
  - sync flops, `filt` (per channel = 00), stability counters, count, rotary_cw and rotary_ccw all go to 0.
  - hex goes to 7'b1000000 on every digit (shows "0").
  - No event is generated by the first post-reset transitions except genuine 01→00 or 10→00 transitions.
- **Reset mid-debounce** discards the partial count.
- **Latency.**
  - A rotary_in change is first captured by sync1 at edge t and is held stable.
  - sync2 changes at t+1.
  - `filt` changes at t+DEBOUNCE+1, or t+2 when DEBOUNCE=0.
  - rotary_cw/ccw and count update one edge after `filt`.
  - hex updates one edge after count.
- **Clear.** clear sampled high at edge t gives count=0 after t and hex "0" after t+1.
- **Pulse rate.** The minimum spacing between pulses on a channel is 2*(DEBOUNCE) cycles, because two filtered bit changes are needed per detent.

## Test plan
- **Reset.** Hold reset_n=0 for 3 cycles with rotary_in=11 → count=0, hex all 7'b1000000, no pulses. After release with rotary_in held at 11 → no pulses, count stays 0.
- **Clockwise steps.** DEBOUNCE=4. Drive ch0 through the sequence 11→10→00→01→11 (wait—cw is defined by entering 00 from 01), i.e. drive 11→01→00, then 00→10→11 per detent, for 3 detents → exactly 3 rotary_cw[0] pulses, each at t+6 after the 00 is applied. count[7:0]=3, HEX0=0110000.
- **Wrap and saturate.**
  - SATURATE=0, count=0xFF, one cw detent → count=0x00.
  - SATURATE=0, then one ccw detent → count=0xFF.
  - SATURATE=1 at 0xFF with a cw detent → count stays 0xFF and the rotary_cw pulse is still seen.
- **Glitch rejection.** DEBOUNCE=500. Drop ch0 A to 0 for 499 cycles, then restore → `filt` unchanged, no pulse, count unchanged.
- **Clear vs event.** Assert clear[1] in the same cycle as a ch1 ccw event at count=5 → count ch1=0, rotary_ccw[1] pulses. Ch0 is unaffected by clear[1].
- **Multi-channel and illegal transition.**
  - Simultaneous cw on ch0 and ccw on ch1 → both pulses in the same cycle; counts become +1 and -1.
  - Forcing ch0 `filt` 11→00 in one step (both bits changed together, DEBOUNCE=0) → no pulse.
